descrambler: RTL and testbench
==============================

DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 SEED, 16'hFFFF, LFSR value loaded at reset and after every COM symbol.
REQ-002 clk1Mhz  input  1  byte-rate clock, the same clock the byte joining stage outputs on.
REQ-003 reset_L  input  1  reset, asynchronous, active-low.
REQ-004 byte_joining_desc_cond  input  8  joined byte from the byte joining stage.
REQ-005 k_in  input  1  control-character flag for the input byte.
REQ-006 valid_in  input  1  input byte qualifier.
REQ-007 data_out  output  8  descrambled byte, registered.
REQ-008 k_out  output  1  registered copy of k_in.
REQ-009 valid_out  output  1  output byte qualifier.
REQ-010 sync_out  output  1  high while in SYNC.
REQ-011 err_out  output  1  one-cycle pulse on an illegal K symbol.

Function
REQ-012 LFSR: 16-bit Galois, G(X)=X^16+X^5+X^4+X^3+1.
REQ-013 One LFSR advance: out bit = lfsr[15]; next = {lfsr[14:0],1'b0} ^ (lfsr[15] ? 16'h0039 : 16'h0000).
REQ-014 Per data byte (k_in=0): eight advances; data_out[i] = din[i] ^ out bit of advance i, for i=0..7 (bit 0 first).
REQ-015 Symbol set: COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, EDB=8'hFE, PAD=8'hF7, IDL=8'h7C; each valid only with k_in=1.
REQ-016 K symbols pass unmodified to data_out.
REQ-017 COM: LFSR loaded with SEED, no advance.
REQ-018 SKP: LFSR holds.
REQ-019 Other legal K symbols: eight advances.
REQ-020 Illegal K (k_in=1, byte not in REQ-015 set): LFSR holds.
REQ-021 valid_in=0: LFSR holds; next-cycle valid_out=0; data_out and k_out hold their previous values.
REQ-022 Latency: exactly one clk1Mhz cycle from valid input to output.
REQ-023 States: UNSYNC and SYNC.
REQ-024 UNSYNC -> SYNC on a valid COM; that COM is output with valid_out=1.
REQ-025 In UNSYNC, every input other than COM produces valid_out=0.
REQ-026 SYNC -> UNSYNC on an illegal K; that symbol produces valid_out=0 and err_out=1 next cycle.
REQ-027 An illegal K in UNSYNC produces err_out=1 and no state change.
REQ-028 In SYNC, every other valid input produces valid_out=1.
REQ-029 A COM in SYNC re-seeds the LFSR and the block stays in SYNC.
REQ-030 The LFSR has no terminal state; it wraps freely and is not re-seeded on wrap.

Reset
REQ-031 reset_L=0 immediately forces all of the following, independent of clk1Mhz: data_out=8'h00, k_out=0, valid_out=0, sync_out=0, err_out=0, LFSR=SEED, state=UNSYNC.
REQ-032 Reset asserted mid-stream discards any in-flight byte.
REQ-033 After reset_L rises, the first valid COM is required before any valid_out=1.

Configuration
REQ-034 Macro DESCR_COM_CNT_EN defined: adds output port com_count (output, 16 bits), a saturating count of COMs accepted in SYNC, including the COM causing UNSYNC->SYNC; reset value 16'h0000; holds at 16'hFFFF.
REQ-035 Macro DESCR_COM_CNT_EN undefined: no com_count port and no counter logic; all other behaviour is identical.

Structure
REQ-036 Shared package descr_pkg holds the K-code constants of REQ-015, the polynomial mask 16'h0039, the default SEED, and the state encoding.
REQ-037 Sub-module descr_lfsr holds the LFSR register with load, hold and 8-step advance controls, and presents the 8-bit mask for the current step.
REQ-038 The state machine, symbol decode and output registers reside in descrambler.

Verification
REQ-039 Reset: reset_L low between clock edges -> all outputs 0 and sync_out 0 before the next edge.
REQ-040 Sync entry: in UNSYNC, data 8'h00 x3 then COM -> valid_out=0 x3, then data_out=8'hBC, k_out=1, valid_out=1, sync_out=1.
REQ-041 Sequence check: COM, 8'h00, 8'h00 -> 8'hBC, 8'hFF, 8'h17.
REQ-042 SKP hold: COM, SKP, 8'h00, 8'h00 -> 8'hBC, 8'h1C, 8'hFF, 8'h17.
REQ-043 Gap: COM, 8'h00, then valid_in=0 for 3 cycles, then 8'h00 -> 8'hFF, valid_out=0 x3 with data_out held at 8'hFF, then 8'h17.
REQ-044 Illegal K: in SYNC, input 8'h55 with k_in=1 -> err_out one-cycle pulse, valid_out=0, sync_out=0; a following COM re-syncs; with DESCR_COM_CNT_EN defined, com_count increments to 2.

Source files
------------

// File: rtl/descr_pkg.sv
// ============================================================================
// descr_pkg : shared K-code constants, LFSR polynomial/seed, state encoding
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package descr_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_IDL = 8'h7C;

  localparam logic [15:0] POLY_MASK = 16'h0039;
  localparam logic [15:0] SEED      = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] state;
    logic [7:0]  mask;
  } lfsr_step_t;

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b == K_COM) || (b == K_SKP) || (b == K_STP) || (b == K_SDP) ||
           (b == K_END) || (b == K_EDB) || (b == K_PAD) || (b == K_IDL);
  endfunction

  // Eight Galois advances; mask bit i is the MSB seen at advance i.
  function automatic lfsr_step_t lfsr_adv8(input logic [15:0] s_in);
    lfsr_step_t r;
    logic [15:0] s;
    s = s_in;
    r.mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r.mask[i] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? POLY_MASK : 16'h0000);
    end
    r.state = s;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/descr_lfsr.sv
// ============================================================================
// descr_lfsr : 16-bit Galois LFSR with load/hold/8-step advance and byte mask
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module descr_lfsr
  import descr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] mask_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  lfsr_step_t  w_step;

  assign w_step = lfsr_adv8(lfsr_q);
  assign mask_o = w_step.mask;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = w_step.state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/descrambler.sv
// ============================================================================
// descrambler : byte-rate LFSR descrambler with COM-based symbol lock
// Optional    : DESCR_COM_CNT_EN adds the com_count saturating COM counter
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module descrambler
  import descr_pkg::*;
(
  input  logic       clk1Mhz,
  input  logic       reset_L,
  input  logic [7:0] byte_joining_desc_cond,
  input  logic       k_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       valid_out,
  output logic       sync_out,
  output logic       err_out
`ifdef DESCR_COM_CNT_EN
  ,
  output logic [15:0] com_count
`endif
);

  state_e     state_q;
  logic [7:0] data_q;
  logic       k_q;
  logic       valid_q;
  logic       err_q;

  logic [7:0] w_mask;
  logic       w_com;
  logic       w_skp;
  logic       w_illegal;
  logic       w_lfsr_load;
  logic       w_lfsr_adv;

  assign w_com     = k_in && (byte_joining_desc_cond == K_COM);
  assign w_skp     = k_in && (byte_joining_desc_cond == K_SKP);
  assign w_illegal = k_in && !is_legal_k(byte_joining_desc_cond);

  // COM reseeds, SKP and illegal K hold; data and other K symbols advance.
  assign w_lfsr_load = valid_in && w_com;
  assign w_lfsr_adv  = valid_in && !w_com && !w_skp && !w_illegal;

  descr_lfsr u_lfsr (
    .clk_i   (clk1Mhz),
    .rst_n_i (reset_L),
    .load_i  (w_lfsr_load),
    .adv_i   (w_lfsr_adv),
    .mask_o  (w_mask)
  );

  always_ff @(posedge clk1Mhz or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_UNSYNC;
      data_q  <= 8'h00;
      k_q     <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (valid_in) begin
        data_q <= k_in ? byte_joining_desc_cond : (byte_joining_desc_cond ^ w_mask);
        k_q    <= k_in;
        if (w_illegal) begin
          err_q   <= 1'b1;
          state_q <= ST_UNSYNC;
        end else if (w_com) begin
          valid_q <= 1'b1;
          state_q <= ST_SYNC;
        end else begin
          valid_q <= (state_q == ST_SYNC);
        end
      end
    end
  end

  assign data_out  = data_q;
  assign k_out     = k_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign sync_out  = (state_q == ST_SYNC);

`ifdef DESCR_COM_CNT_EN
  logic [15:0] com_cnt_q;

  always_ff @(posedge clk1Mhz or negedge reset_L) begin
    if (!reset_L) begin
      com_cnt_q <= 16'h0000;
    end else if (valid_in && w_com && (com_cnt_q != 16'hFFFF)) begin
      com_cnt_q <= com_cnt_q + 16'h0001;
    end
  end

  assign com_count = com_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_descrambler.sv
// ============================================================================
// tb_descrambler : directed + scoreboard bench for descrambler
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_descrambler;

  logic        clk1Mhz = 1'b0;
  logic        reset_L = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        k_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_out;
  logic        k_out;
  logic        valid_out;
  logic        sync_out;
  logic        err_out;
`ifdef DESCR_COM_CNT_EN
  logic [15:0] com_count;
`endif

  always #5 clk1Mhz = ~clk1Mhz;

  descrambler dut (
    .clk1Mhz                (clk1Mhz),
    .reset_L                (reset_L),
    .byte_joining_desc_cond (byte_in),
    .k_in                   (k_in),
    .valid_in               (valid_in),
    .data_out               (data_out),
    .k_out                  (k_out),
    .valid_out              (valid_out),
    .sync_out               (sync_out),
    .err_out                (err_out)
`ifdef DESCR_COM_CNT_EN
    ,
    .com_count              (com_count)
`endif
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        k;
    logic        v;
    logic        s;
    logic        e;
    logic        cd;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [15:0] m_lfsr = 16'hFFFF;
  logic        m_sync = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic        m_k    = 1'b0;
  logic [15:0] m_cnt  = 16'h0000;

  function automatic logic legal_k(input logic [7:0] b);
    case (b)
      8'hBC, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'hF7, 8'h7C: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hFFFF;
    m_sync = 1'b0;
    m_data = 8'h00;
    m_k    = 1'b0;
    m_cnt  = 16'h0000;
  endtask

  task automatic model_advance(output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = m_lfsr[15];
      if (m_lfsr[15]) m_lfsr = {m_lfsr[14:0], 1'b0} ^ 16'h0039;
      else            m_lfsr = {m_lfsr[14:0], 1'b0};
    end
  endtask

  task automatic step(input logic [7:0] d, input logic k, input logic v);
    exp_t       e;
    logic [7:0] m;
    e = '0;
    if (!v) begin
      e.cd = m_sync;
    end else if (k && !legal_k(d)) begin
      m_sync = 1'b0;
      e.e = 1'b1;
      m_data = d; m_k = 1'b1;
    end else if (k && d == 8'hBC) begin
      m_lfsr = 16'hFFFF;
      m_sync = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
      e.v = 1'b1; e.cd = 1'b1;
      m_data = d; m_k = 1'b1;
    end else if (k) begin
      if (d != 8'h1C) model_advance(m);
      e.v = m_sync; e.cd = m_sync;
      m_data = d; m_k = 1'b1;
    end else begin
      model_advance(m);
      e.v = m_sync; e.cd = m_sync;
      m_data = d ^ m; m_k = 1'b0;
    end
    e.d = m_data; e.k = m_k; e.s = m_sync; e.cnt = m_cnt;
    sb.push_back(e);

    @(negedge clk1Mhz);
    byte_in = d; k_in = k; valid_in = v;
    @(posedge clk1Mhz);
    #1;
    e = sb.pop_front();
    check("valid_out", {15'd0, valid_out}, {15'd0, e.v});
    check("sync_out",  {15'd0, sync_out},  {15'd0, e.s});
    check("err_out",   {15'd0, err_out},   {15'd0, e.e});
    if (e.cd) begin
      check("data_out", {8'd0, data_out}, {8'd0, e.d});
      check("k_out",    {15'd0, k_out},   {15'd0, e.k});
    end
`ifdef DESCR_COM_CNT_EN
    check("com_count", com_count, e.cnt);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  {8'd0, data_out},  16'h0000);
    check({tag, "_k"},     {15'd0, k_out},    16'h0000);
    check({tag, "_valid"}, {15'd0, valid_out}, 16'h0000);
    check({tag, "_sync"},  {15'd0, sync_out}, 16'h0000);
    check({tag, "_err"},   {15'd0, err_out},  16'h0000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ksym [8];
    logic [7:0] r;
    ksym = '{8'hBC, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'hF7, 8'h7C};

    // Power-on reset between edges
    #1 reset_L = 1'b0;
    #1 check_all_zero("por");
`ifdef DESCR_COM_CNT_EN
    check("por_cnt", com_count, 16'h0000);
`endif
    @(negedge clk1Mhz);
    reset_L = 1'b1;
    model_reset();

    // Sync entry: data ignored until COM
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'hBC, 1'b1, 1'b1);
    check("entry_data", {8'd0, data_out}, 16'h00BC);
    check("entry_sync", {15'd0, sync_out}, 16'h0001);

    // Illegal K in SYNC, one-cycle error pulse, then re-sync
    step(8'h55, 1'b1, 1'b1);
    check("ill_err", {15'd0, err_out}, 16'h0001);
    step(8'h00, 1'b0, 1'b1);
    step(8'hBC, 1'b1, 1'b1);
`ifdef DESCR_COM_CNT_EN
    check("ill_cnt2", com_count, 16'h0002);
`endif

    // COM, 00, 00
    step(8'hBC, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    check("seq_b1", {8'd0, data_out}, 16'h00FF);
    step(8'h00, 1'b0, 1'b1);
    check("seq_b2", {8'd0, data_out}, 16'h0017);

    // SKP holds the LFSR
    step(8'hBC, 1'b1, 1'b1);
    step(8'h1C, 1'b1, 1'b1);
    check("skp_pass", {8'd0, data_out}, 16'h001C);
    step(8'h00, 1'b0, 1'b1);
    check("skp_b1", {8'd0, data_out}, 16'h00FF);
    step(8'h00, 1'b0, 1'b1);
    check("skp_b2", {8'd0, data_out}, 16'h0017);

    // Gap: valid_in low holds LFSR and outputs
    step(8'hBC, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'hA5, 1'b0, 1'b0);
      check("gap_hold", {8'd0, data_out}, 16'h00FF);
    end
    step(8'h00, 1'b0, 1'b1);
    check("gap_b2", {8'd0, data_out}, 16'h0017);

    // Other legal K symbols advance the LFSR by one byte
    step(8'hBC, 1'b1, 1'b1);
    step(8'hFD, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    check("endk_adv", {8'd0, data_out}, 16'h0017);
    step(8'hBC, 1'b1, 1'b1);
    step(8'h7C, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    check("idlk_adv", {8'd0, data_out}, 16'h0017);

    // Randomised mixed traffic against the model
    step(8'hBC, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      r = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       step(r, 1'b0, 1'b0);
        1, 2:    step(ksym[$urandom_range(0, 7)], 1'b1, 1'b1);
        default: step(r, 1'b0, 1'b1);
      endcase
    end

    // Mid-stream reset discards the in-flight byte
    @(negedge clk1Mhz);
    byte_in = 8'h00; k_in = 1'b0; valid_in = 1'b1;
    #2 reset_L = 1'b0;
    #1 check_all_zero("mid_rst");
    @(posedge clk1Mhz);
    #1 check_all_zero("mid_rst_edge");
    @(negedge clk1Mhz);
    reset_L = 1'b1; valid_in = 1'b0;
    model_reset();
    step(8'h00, 1'b0, 1'b1);
    check("post_rst_nosync", {15'd0, valid_out}, 16'h0000);
    step(8'hBC, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    check("post_rst_b1", {8'd0, data_out}, 16'h00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
